airi5c_operand_unpacker: RTL and testbench

//  Register-stage unpacker that sits directly upstream of the FPU classifier and the arithmetic units.

---
 rtl/airi5c_operand_unpacker_pkg.sv | 31 +++
 rtl/airi5c_float_field_decode.sv | 42 ++++
 rtl/airi5c_operand_unpacker.sv | 109 ++++++++++
 tb/tb_airi5c_operand_unpacker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_operand_unpacker_pkg.sv
// Shared binary32 field positions, exponent constants and unpacker FSM encoding.
// Imported by airi5c_float_field_decode and airi5c_operand_unpacker.
package airi5c_operand_unpacker_pkg;

  localparam int BIAS       = 127;
  localparam int EMIN       = -126;
  localparam int EXP_INFNAN = 128;

  localparam int SGN_BIT   = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FRAC_MSB  = 22;
  localparam int FRAC_LSB  = 0;
  localparam int QUIET_BIT = 22;
  localparam int MAN_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic sNaN;
    logic qNaN;
    logic denormal;
  } class_t;

endpackage

// File: rtl/airi5c_float_field_decode.sv
// Combinational split of a binary32 operand into sign, unbiased exponent,
// significand and class flags.
module airi5c_float_field_decode
  import airi5c_operand_unpacker_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic [31:0]             i_float,
  output logic                    o_sgn,
  output logic signed [EXP_W-1:0] o_exp,
  output logic [MAN_W-1:0]        o_man,
  output class_t                  o_class
);

  logic [7:0]  w_e;
  logic [22:0] w_f;
  logic        w_fNonZero;

  assign w_e        = i_float[EXP_MSB:EXP_LSB];
  assign w_f        = i_float[FRAC_MSB:FRAC_LSB];
  assign w_fNonZero = |w_f;
  assign o_sgn      = i_float[SGN_BIT];

  always_comb begin
    o_class = '0;
    o_man   = {1'b1, w_f};
    o_exp   = EXP_W'(int'(w_e) - BIAS);
    if (w_e == 8'h00) begin
      // Zero and denormals share the minimum exponent; the hidden bit is clear.
      o_exp            = EXP_W'(EMIN);
      o_man            = {1'b0, w_f};
      o_class.zero     = !w_fNonZero;
      o_class.denormal = w_fNonZero;
    end else if (w_e == 8'hFF) begin
      o_exp        = EXP_W'(EXP_INFNAN);
      o_class.inf  = !w_fNonZero;
      o_class.qNaN = w_f[QUIET_BIT];
      o_class.sNaN = w_fNonZero && !w_f[QUIET_BIT];
    end
  end

endmodule

// File: rtl/airi5c_operand_unpacker.sv
// Registered binary32 operand unpacker with load/kill/ready handshake.
// Define AIRI5C_UNPACK_NORM_EN to normalize denormal significands before ready.
module airi5c_operand_unpacker
  import airi5c_operand_unpacker_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    kill,
  input  logic                    load,
  input  logic [31:0]             float_in,
  output logic                    sgn,
  output logic signed [EXP_W-1:0] exp,
  output logic [MAN_W-1:0]        man,
  output logic                    zero,
  output logic                    inf,
  output logic                    sNaN,
  output logic                    qNaN,
  output logic                    denormal,
  output logic                    ready
);

  state_t                  r_state;
  state_t                  w_stateNext;
  logic                    r_sgn;
  logic signed [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0]        r_man;
  class_t                  r_class;

  logic                    w_sgn;
  logic signed [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0]        w_man;
  class_t                  w_class;

  airi5c_float_field_decode #(
    .EXP_W(EXP_W)
  ) u_decode (
    .i_float(float_in),
    .o_sgn  (w_sgn),
    .o_exp  (w_exp),
    .o_man  (w_man),
    .o_class(w_class)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_stateNext;
  end

  // kill beats load; a load in any state restarts with the new operand.
  always_comb begin
    w_stateNext = r_state;
    if (kill) begin
      w_stateNext = ST_IDLE;
    end else if (load) begin
`ifdef AIRI5C_UNPACK_NORM_EN
      w_stateNext = w_class.denormal ? ST_NORM : ST_DONE;
`else
      w_stateNext = ST_DONE;
`endif
    end else begin
      case (r_state)
        ST_IDLE: w_stateNext = ST_IDLE;
`ifdef AIRI5C_UNPACK_NORM_EN
        ST_NORM: w_stateNext = r_man[MAN_W-2] ? ST_DONE : ST_NORM;
`endif
        ST_DONE: w_stateNext = ST_IDLE;
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sgn   <= 1'b0;
      r_exp   <= '0;
      r_man   <= '0;
      r_class <= '0;
    end else if (kill) begin
      r_sgn   <= 1'b0;
      r_exp   <= '0;
      r_man   <= '0;
      r_class <= '0;
    end else if (load) begin
      r_sgn   <= w_sgn;
      r_exp   <= w_exp;
      r_man   <= w_man;
      r_class <= w_class;
`ifdef AIRI5C_UNPACK_NORM_EN
    end else if (r_state == ST_NORM) begin
      // Class flags stay as captured; only the significand and exponent move.
      r_man <= r_man << 1;
      r_exp <= r_exp - EXP_W'(1);
`endif
    end
  end

  assign sgn      = r_sgn;
  assign exp      = r_exp;
  assign man      = r_man;
  assign zero     = r_class.zero;
  assign inf      = r_class.inf;
  assign sNaN     = r_class.sNaN;
  assign qNaN     = r_class.qNaN;
  assign denormal = r_class.denormal;
  assign ready    = (r_state == ST_DONE);

endmodule

// File: tb/tb_airi5c_operand_unpacker.sv
// Scoreboard bench for airi5c_operand_unpacker; honours AIRI5C_UNPACK_NORM_EN
// when the same define is given to the bench and the design.
module tb_airi5c_operand_unpacker;

  localparam int EXP_W = 10;
  localparam int GAP   = 30;
`ifdef AIRI5C_UNPACK_NORM_EN
  localparam bit NORM_EN = 1'b1;
`else
  localparam bit NORM_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    n_reset;
  logic                    kill;
  logic                    load;
  logic [31:0]             float_in;
  logic                    sgn;
  logic signed [EXP_W-1:0] exp;
  logic [23:0]             man;
  logic                    zero;
  logic                    inf;
  logic                    sNaN;
  logic                    qNaN;
  logic                    denormal;
  logic                    ready;

  typedef struct packed {
    logic        sgn;
    logic [31:0] expV;
    logic [23:0] man;
    logic [4:0]  flags;
    logic [31:0] readyCycle;
  } expect_t;

  expect_t sbQueue[$];
  int      checks = 0;
  int      errors = 0;
  int      cycleCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  airi5c_operand_unpacker #(
    .EXP_W(EXP_W)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .kill    (kill),
    .load    (load),
    .float_in(float_in),
    .sgn     (sgn),
    .exp     (exp),
    .man     (man),
    .zero    (zero),
    .inf     (inf),
    .sNaN    (sNaN),
    .qNaN    (qNaN),
    .denormal(denormal),
    .ready   (ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at cycle %0d",
               tag, observed, expected, cycleCount);
    end
  endtask

  // Reference decode of a binary32 operand, including optional normalization.
  function automatic expect_t modelOperand(input logic [31:0] f, input int startCycle);
    expect_t     r;
    logic [7:0]  e;
    logic [22:0] fr;
    int          expV;
    logic [23:0] m;
    int          lat;
    logic        z, i, s, q, d;
    e  = f[30:23];
    fr = f[22:0];
    z = 1'b0; i = 1'b0; s = 1'b0; q = 1'b0; d = 1'b0;
    lat = 1;
    if (e == 8'd0) begin
      expV = -126;
      m    = {1'b0, fr};
      z    = (fr == 23'd0);
      d    = (fr != 23'd0);
      if (NORM_EN && d) begin
        while (m[23] == 1'b0) begin
          m    = m << 1;
          expV = expV - 1;
          lat  = lat + 1;
        end
      end
    end else if (e == 8'd255) begin
      expV = 128;
      m    = {1'b1, fr};
      i    = (fr == 23'd0);
      q    = fr[22];
      s    = (fr != 23'd0) && !fr[22];
    end else begin
      expV = int'(e) - 127;
      m    = {1'b1, fr};
    end
    r.sgn        = f[31];
    r.expV       = 32'(expV);
    r.man        = m;
    r.flags      = {z, i, s, q, d};
    r.readyCycle = 32'(startCycle + lat);
    return r;
  endfunction

  always @(negedge clk) begin
    expect_t x;
    if (ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spurious_ready", 32'(ready), 32'd0);
      end else begin
        x = sbQueue.pop_front();
        checkOutput("ready_cycle", 32'(cycleCount), x.readyCycle);
        checkOutput("sgn", 32'(sgn), 32'(x.sgn));
        checkOutput("exp", 32'(exp), x.expV);
        checkOutput("man", 32'(man), 32'(x.man));
        checkOutput("flags", 32'({zero, inf, sNaN, qNaN, denormal}), 32'(x.flags));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] f, input bit expectReady);
    @(posedge clk);
    #1;
    load     = 1'b1;
    kill     = 1'b0;
    float_in = f;
    if (expectReady) sbQueue.push_back(modelOperand(f, cycleCount));
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk);
    #1;
    load = 1'b0;
    kill = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("drain_timeout", 32'(sbQueue.size()), 32'd0);
      sbQueue.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sgn"}, 32'(sgn), 32'd0);
    checkOutput({tag, "_exp"}, 32'(exp), 32'd0);
    checkOutput({tag, "_man"}, 32'(man), 32'd0);
    checkOutput({tag, "_flags"}, 32'({zero, inf, sNaN, qNaN, denormal}), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  initial begin
    logic [31:0] vectors[12];
    vectors = '{32'h3F800000, 32'hFF800000, 32'h7FA00000, 32'h7FC00000,
                32'h00000001, 32'h80000000, 32'h7F7FFFFF, 32'h00800000,
                32'h00400000, 32'h807FFFFF, 32'h7F800000, 32'hFFFFFFFF};
    n_reset  = 1'b0;
    kill     = 1'b0;
    load     = 1'b0;
    float_in = 32'd0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("post_reset");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vectors[i], 1'b1);
      idleCycles(GAP);
    end

    // Back-to-back normals: each load restarts from DONE.
    applyStimulus(32'h40490FDB, 1'b1);
    applyStimulus(32'hC2F60000, 1'b1);
    applyStimulus(32'h3F800000, 1'b1);
    idleCycles(5);
    waitDrain();

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, 1'b1);
      idleCycles(GAP);
    end
    waitDrain();

    // Outputs hold after ready.
    applyStimulus(32'h3F800000, 1'b1);
    idleCycles(5);
    waitDrain();
    @(negedge clk);
    checkOutput("hold_exp", 32'(exp), 32'd0);
    checkOutput("hold_man", 32'(man), 32'h00800000);
    checkOutput("hold_ready", 32'(ready), 32'd0);

    // Restart: a denormal abandoned one cycle later by a normal operand.
    applyStimulus(32'h00400000, !NORM_EN);
    applyStimulus(32'h3F800000, 1'b1);
    idleCycles(5);
    waitDrain();

    // Kill alone clears held outputs.
    applyStimulus(32'hFF800000, 1'b1);
    idleCycles(3);
    waitDrain();
    @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    checkAllZero("kill");

    // kill and load together: nothing is captured.
    applyStimulus(32'h7FC00000, 1'b1);
    idleCycles(3);
    waitDrain();
    @(posedge clk);
    #1;
    kill     = 1'b1;
    load     = 1'b1;
    float_in = 32'h3F800000;
    idleCycles(5);
    @(negedge clk);
    checkAllZero("kill_load");

    // Kill part-way through a long denormal.
    applyStimulus(32'h00000001, !NORM_EN);
    idleCycles(3);
    @(negedge clk);
    checkOutput("mid_flags", 32'({zero, inf, sNaN, qNaN, denormal}), 32'h00000001);
    @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    checkAllZero("mid_kill");
    idleCycles(GAP);
    waitDrain();

    // Asynchronous reset part-way through a long denormal.
    applyStimulus(32'h00000001, !NORM_EN);
    idleCycles(4);
    #3 n_reset = 1'b0;
    #1 checkAllZero("mid_reset");
    @(negedge clk);
    n_reset = 1'b1;
    idleCycles(GAP);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
    $fatal(1, "[TB] watchdog");
  end

endmodule
